// File: rtl/pwm_analyzer_scheduler_pkg.sv
// pwm_analyzer_scheduler_pkg
//   Shared types for the PWM analyzer scheduler: FSM state encoding and a
//   constant-function clog2 used to size counters and channel indices.
package pwm_analyzer_scheduler_pkg;

  typedef enum logic [2:0] {
    ST_IDLE    = 3'd0,
    ST_SELECT  = 3'd1,
    ST_CLEAR   = 3'd2,
    ST_DWELL   = 3'd3,
    ST_CAPTURE = 3'd4
  } state_t;

  // Ceiling log2; clog2(1) = 0, clog2(8) = 3, clog2(2000) = 11.
  function automatic int clog2(input int value);
    int r;
    int v;
    r = 0;
    v = value - 1;
    for (int i = 0; i < 32; i++) begin
      if (v > 0) begin
        r = r + 1;
        v = v >> 1;
      end
    end
    return r;
  endfunction

endpackage

// File: rtl/pwm_analyzer_scheduler_sync.sv
// pwm_sync
//   Two-flop synchronizer for asynchronous inputs, reset to 0.
//   i_clk   : sampling clock
//   i_rst_n : asynchronous active-low reset
//   i_d     : asynchronous input bits
//   o_q     : synchronized bits, two clock edges after i_d
module pwm_sync #(
  parameter int WIDTH = 1
) (
  input  logic             i_clk,
  input  logic             i_rst_n,
  input  logic [WIDTH-1:0] i_d,
  output logic [WIDTH-1:0] o_q
);

  // r_pipe[0] may go metastable; r_pipe[1] is the settled copy.
  logic [1:0][WIDTH-1:0] r_pipe;

  always_ff @(posedge i_clk or negedge i_rst_n) begin
    if (!i_rst_n) r_pipe <= '0;
    else          r_pipe <= {r_pipe[0], i_d};
  end

  assign o_q = r_pipe[1];

endmodule

// File: rtl/pwm_analyzer_scheduler.sv
// pwm_analyzer_scheduler
//   Time-shares one pwm_analyzer between NUM_CHANNELS PWM inputs. Each
//   enabled channel is visited round-robin: the analyzer is cleared, fed the
//   synchronized PWM line for DWELL_CYCLES cycles, and its output level is
//   stored in that channel's result bit.
//
//   clock_i           : system clock, rising edge
//   reset_i           : asynchronous active-low reset
//   run_i             : 1 keeps scheduling; 0 stops after the current visit
//   channel_mask_i    : per-channel participation
//   pwm_i             : asynchronous PWM pins
//   analyzer_level_i  : output of the shared analyzer
//   analyzer_enable_o : analyzer enable (PWM of the active channel in DWELL)
//   analyzer_clear_o  : analyzer clear, active high
//   active_channel_o  : channel currently owning the analyzer
//   busy_o            : high whenever the scheduler is not idle
//   levels_o          : last captured level per channel
//   update_o          : one-cycle pulse when a level is captured
//   update_channel_o  : channel written on update_o
module pwm_analyzer_scheduler
  import pwm_analyzer_scheduler_pkg::*;
#(
  parameter int NUM_CHANNELS = 4,
  parameter int CH_BITS      = 2,
  parameter int DWELL_CYCLES = 2000
) (
  input  logic                    clock_i,
  input  logic                    reset_i,
  input  logic                    run_i,
  input  logic [NUM_CHANNELS-1:0] channel_mask_i,
  input  logic [NUM_CHANNELS-1:0] pwm_i,
  input  logic                    analyzer_level_i,
  output logic                    analyzer_enable_o,
  output logic                    analyzer_clear_o,
  output logic [CH_BITS-1:0]      active_channel_o,
  output logic                    busy_o,
  output logic [NUM_CHANNELS-1:0] levels_o,
  output logic                    update_o,
  output logic [CH_BITS-1:0]      update_channel_o
);

  localparam int                CNT_W    = clog2(DWELL_CYCLES);
  localparam logic [CNT_W-1:0]  CNT_LAST = CNT_W'(DWELL_CYCLES - 1);
  localparam logic [CH_BITS-1:0] CH_LAST = CH_BITS'(NUM_CHANNELS - 1);

  state_t                  r_state, w_state_nxt;
  logic [CH_BITS-1:0]      r_active;
  logic [CH_BITS-1:0]      r_last;
  logic [CNT_W-1:0]        r_cnt;
  logic [NUM_CHANNELS-1:0] r_levels;

  logic [NUM_CHANNELS-1:0] w_pwm_s;
  logic [CH_BITS-1:0]      w_next_ch;
  logic                    w_mask_any;
  logic                    w_active_en;
  logic                    w_enable;
  logic                    w_clear;
  logic                    w_busy;
  logic                    w_update;

  // One synchronizer per pin so every channel is already settled when
  // the scheduler switches to it.
  for (genvar g = 0; g < NUM_CHANNELS; g++) begin : g_sync
    pwm_sync #(.WIDTH(1)) u_sync (
      .i_clk   (clock_i),
      .i_rst_n (reset_i),
      .i_d     (pwm_i[g]),
      .o_q     (w_pwm_s[g])
    );
  end

  assign w_mask_any  = |channel_mask_i;
  assign w_active_en = channel_mask_i[r_active];

  // Round-robin search: first set mask bit strictly after r_last, wrapping.
  // Offset NUM_CHANNELS lands back on r_last, so a lone channel reselects
  // itself.
  always_comb begin
    logic               found;
    logic [CH_BITS-1:0] idx;
    found     = 1'b0;
    idx       = '0;
    w_next_ch = r_last;
    for (int i = 1; i <= NUM_CHANNELS; i++) begin
      idx = CH_BITS'((int'(r_last) + i) % NUM_CHANNELS);
      if (!found && channel_mask_i[idx]) begin
        found     = 1'b1;
        w_next_ch = idx;
      end
    end
  end

  always_ff @(posedge clock_i or negedge reset_i) begin
    if (!reset_i) r_state <= ST_IDLE;
    else          r_state <= w_state_nxt;
  end

  always_comb begin
    w_state_nxt = r_state;
    w_enable    = 1'b0;
    w_clear     = 1'b0;
    w_busy      = 1'b1;
    w_update    = 1'b0;
    case (r_state)
      ST_IDLE: begin
        w_clear = 1'b1;
        w_busy  = 1'b0;
        if (run_i && w_mask_any) w_state_nxt = ST_SELECT;
      end
      ST_SELECT: begin
        w_state_nxt = w_mask_any ? ST_CLEAR : ST_IDLE;
      end
      ST_CLEAR: begin
        w_clear     = 1'b1;
        w_state_nxt = ST_DWELL;
      end
      ST_DWELL: begin
        w_enable = w_pwm_s[r_active];
        // Losing the active channel abandons the visit without a capture.
        if (!w_active_en)           w_state_nxt = ST_SELECT;
        else if (r_cnt == CNT_LAST) w_state_nxt = ST_CAPTURE;
      end
      ST_CAPTURE: begin
        w_update    = 1'b1;
        w_state_nxt = (run_i && w_mask_any) ? ST_SELECT : ST_IDLE;
      end
      default: begin
        w_clear     = 1'b1;
        w_busy      = 1'b0;
        w_state_nxt = ST_IDLE;
      end
    endcase
  end

  always_ff @(posedge clock_i or negedge reset_i) begin
    if (!reset_i) begin
      r_active <= '0;
      r_last   <= CH_LAST;
      r_cnt    <= '0;
      r_levels <= '0;
    end else begin
      case (r_state)
        ST_SELECT: begin
          if (w_mask_any) begin
            r_active <= w_next_ch;
            r_last   <= w_next_ch;
          end
        end
        ST_CLEAR:   r_cnt <= '0;
        ST_DWELL:   r_cnt <= r_cnt + 1'b1;
        ST_CAPTURE: r_levels[r_active] <= analyzer_level_i;
        default: ;
      endcase
    end
  end

  assign analyzer_enable_o = w_enable;
  assign analyzer_clear_o  = w_clear;
  assign busy_o            = w_busy;
  assign update_o          = w_update;
  assign active_channel_o  = r_active;
  assign update_channel_o  = r_active;
  assign levels_o          = r_levels;

endmodule

// File: tb/tb_pwm_analyzer_scheduler.sv
module tb_pwm_analyzer_scheduler;

  localparam int NC = 4;
  localparam int DW = 8;

  logic          clk = 1'b0;
  logic          rst_n = 1'b0;
  logic          run = 1'b0;
  logic [NC-1:0] mask = '0;
  logic [NC-1:0] pwm = '0;
  logic          an_level;
  logic          en, clr, busy, upd;
  logic [1:0]    act, upd_ch;
  logic [NC-1:0] levels;

  int vectors = 0;
  int miscompares = 0;
  int cyc = 0;
  int an_cnt = 0;
  int m_last = NC - 1;
  logic [NC-1:0] exp_levels = '0;
  logic [NC-1:0] hist [0:16383];

  pwm_analyzer_scheduler #(
    .NUM_CHANNELS (NC),
    .CH_BITS      (2),
    .DWELL_CYCLES (DW)
  ) dut (
    .clock_i           (clk),
    .reset_i           (rst_n),
    .run_i             (run),
    .channel_mask_i    (mask),
    .pwm_i             (pwm),
    .analyzer_level_i  (an_level),
    .analyzer_enable_o (en),
    .analyzer_clear_o  (clr),
    .active_channel_o  (act),
    .busy_o            (busy),
    .levels_o          (levels),
    .update_o          (upd),
    .update_channel_o  (upd_ch)
  );

  always #5 clk = ~clk;

  // hist[k] = pin value sampled by rising edge number k.
  always @(posedge clk) begin
    hist[cyc] <= pwm;
    cyc <= cyc + 1;
  end

  // Behavioural analyzer: counts enabled cycles since clear, high above 4.
  always @(posedge clk) begin
    if (clr)     an_cnt <= 0;
    else if (en) an_cnt <= an_cnt + 1;
  end
  assign an_level = (an_cnt > 4);

  initial begin
    #300000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1, "timeout");
  end

  function automatic int next_ch(input logic [NC-1:0] m, input int last);
    for (int i = 1; i <= NC; i++)
      if (m[(last + i) % NC]) return (last + i) % NC;
    return -1;
  endfunction

  // A visit whose SELECT follows edge sel dwells in the cycles after edges
  // sel+2..sel+9; with two-edge pin latency the analyzer sees pins sampled
  // at edges sel+1..sel+8.
  function automatic logic exp_level(input int ch, input int sel);
    int s;
    logic [NC-1:0] h;
    s = 0;
    for (int j = sel + 1; j <= sel + 8; j++) begin
      h = hist[j];
      s += int'(h[2'(ch)]);
    end
    return (s > 4);
  endfunction

  task automatic apply_reset();
    run = 1'b0; mask = '0; pwm = '0;
    @(negedge clk); rst_n = 1'b0;
    repeat (3) @(negedge clk);
    rst_n = 1'b1;
    m_last = NC - 1;
    exp_levels = '0;
    repeat (2) @(negedge clk);
  endtask

  task automatic wait_idle(input string tag);
    bit ok;
    ok = 1'b0;
    run = 1'b0;
    for (int i = 0; i < 40 && !ok; i++) begin
      @(negedge clk);
      if (busy === 1'b0) ok = 1'b1;
    end
    vectors++;
    if (!ok) begin
      miscompares++;
      $display("FAIL %s idle_wait: busy still %b after 40 cycles", tag, busy);
    end
  endtask

  // Runs nvis visits over mask m from IDLE, checking every cycle.
  task automatic test_schedule(input string tag, input logic [NC-1:0] m,
                               input int nvis, input bit rnd,
                               input logic [NC-1:0] pc);
    int s, ch;
    logic [1:0] c2;
    logic [NC-1:0] h;
    logic e_en;
    wait_idle(tag);
    @(negedge clk);
    mask = m; pwm = pc; run = 1'b1; s = cyc;
    for (int v = 0; v < nvis; v++) begin
      ch = next_ch(m, m_last);
      m_last = ch;
      c2 = 2'(ch);
      for (int k = 0; k <= 10; k++) begin
        @(negedge clk);
        h = hist[s + k - 1];
        e_en = (k >= 2 && k <= 9) ? h[c2] : 1'b0;
        vectors++;
        if (upd !== (k == 10) || busy !== 1'b1 || clr !== (k == 1) ||
            en !== e_en) begin
          miscompares++;
          $display("FAIL %s ctl v%0d k%0d: upd=%b busy=%b clr=%b en=%b, want upd=%b busy=1 clr=%b en=%b",
                   tag, v, k, upd, busy, clr, en, k == 10, k == 1, e_en);
        end
        if (k >= 1) begin
          vectors++;
          if (act !== c2) begin
            miscompares++;
            $display("FAIL %s active v%0d k%0d: got %0d want %0d", tag, v, k, act, c2);
          end
        end
        if (k == 0) begin
          vectors++;
          if (levels !== exp_levels) begin
            miscompares++;
            $display("FAIL %s levels v%0d: got %b want %b", tag, v, levels, exp_levels);
          end
        end
        if (k == 10) begin
          vectors++;
          if (upd_ch !== c2) begin
            miscompares++;
            $display("FAIL %s upd_ch v%0d: got %0d want %0d", tag, v, upd_ch, c2);
          end
          exp_levels[c2] = exp_level(ch, s);
          if (v == nvis - 1) run = 1'b0;
        end
        if (rnd) pwm = NC'($urandom);
      end
      s += 11;
    end
    @(negedge clk);
    vectors++;
    if (busy !== 1'b0 || clr !== 1'b1 || en !== 1'b0 || levels !== exp_levels) begin
      miscompares++;
      $display("FAIL %s stop: busy=%b clr=%b en=%b lv=%b, want 0 1 0 %b",
               tag, busy, clr, en, levels, exp_levels);
    end
  endtask

  task automatic test_reset();
    run = 1'b0; mask = '0; pwm = '0; rst_n = 1'b0;
    repeat (2) @(negedge clk);
    vectors++;
    if (busy !== 0 || clr !== 1 || en !== 0 || levels !== 0 || upd !== 0 ||
        act !== 0 || upd_ch !== 0) begin
      miscompares++;
      $display("FAIL reset_hold: busy=%b clr=%b en=%b lv=%b upd=%b act=%0d uch=%0d",
               busy, clr, en, levels, upd, act, upd_ch);
    end
    rst_n = 1'b1;
    m_last = NC - 1; exp_levels = '0;
    repeat (2) @(negedge clk);
    vectors++;
    if (busy !== 0 || clr !== 1 || en !== 0 || levels !== 0 || upd !== 0) begin
      miscompares++;
      $display("FAIL reset_release: busy=%b clr=%b en=%b lv=%b upd=%b",
               busy, clr, en, levels, upd);
    end
  endtask

  task automatic test_all_channels();
    apply_reset();
    test_schedule("all", 4'b1111, 4, 1'b0, 4'b1111);
    vectors++;
    if (levels !== 4'b1111) begin
      miscompares++;
      $display("FAIL all_levels: got %b want 1111", levels);
    end
  endtask

  task automatic test_alternate();
    apply_reset();
    test_schedule("alt", 4'b1010, 4, 1'b0, 4'b0010);
    vectors++;
    if (levels !== 4'b0010) begin
      miscompares++;
      $display("FAIL alt_levels: got %b want 0010", levels);
    end
  endtask

  task automatic test_single();
    apply_reset();
    test_schedule("single", 4'b0100, 3, 1'b0, 4'b0100);
    vectors++;
    if (levels !== 4'b0100) begin
      miscompares++;
      $display("FAIL single_levels: got %b want 0100", levels);
    end
  endtask

  task automatic test_abort();
    int s;
    apply_reset();
    @(negedge clk);
    mask = 4'b1111; pwm = 4'b1111; run = 1'b1; s = cyc;
    // Drop channel 0 during its third dwell cycle (k = 4).
    for (int k = 0; k <= 4; k++) begin
      @(negedge clk);
      vectors++;
      if (upd !== 1'b0 || busy !== 1'b1) begin
        miscompares++;
        $display("FAIL abort_pre k%0d: upd=%b busy=%b want 0 1", k, upd, busy);
      end
      if (k == 4) mask = 4'b1110;
    end
    @(negedge clk);
    vectors++;
    if (upd !== 0 || busy !== 1 || clr !== 0 || en !== 0) begin
      miscompares++;
      $display("FAIL abort_select: upd=%b busy=%b clr=%b en=%b want 0 1 0 0", upd, busy, clr, en);
    end
    s = s + 5;
    for (int k = 1; k <= 10; k++) begin
      @(negedge clk);
      vectors++;
      if (act !== 2'd1 || upd !== (k == 10) || clr !== (k == 1)) begin
        miscompares++;
        $display("FAIL abort_next k%0d: act=%0d upd=%b clr=%b want 1 %b %b",
                 k, act, upd, clr, k == 10, k == 1);
      end
      if (k == 10) run = 1'b0;
    end
    @(negedge clk);
    vectors++;
    if (levels !== 4'b0010 || busy !== 1'b0) begin
      miscompares++;
      $display("FAIL abort_levels: lv=%b busy=%b want 0010 0", levels, busy);
    end
    m_last = 1;
  endtask

  task automatic test_run_drop();
    apply_reset();
    @(negedge clk);
    mask = 4'b0011; pwm = 4'b1111; run = 1'b1;
    for (int k = 0; k <= 10; k++) begin
      @(negedge clk);
      vectors++;
      if (upd !== (k == 10) || busy !== 1'b1) begin
        miscompares++;
        $display("FAIL drop k%0d: upd=%b busy=%b want %b 1", k, upd, busy, k == 10);
      end
      if (k == 5) run = 1'b0;
      if (k == 10) begin
        vectors++;
        if (upd_ch !== 2'd0) begin
          miscompares++;
          $display("FAIL drop_uch: got %0d want 0", upd_ch);
        end
      end
    end
    for (int i = 0; i < 3; i++) begin
      @(negedge clk);
      vectors++;
      if (busy !== 0 || clr !== 1 || upd !== 0 || levels !== 4'b0001) begin
        miscompares++;
        $display("FAIL drop_idle %0d: busy=%b clr=%b upd=%b lv=%b want 0 1 0 0001",
                 i, busy, clr, upd, levels);
      end
    end
  endtask

  task automatic test_async_reset();
    apply_reset();
    @(negedge clk);
    mask = 4'b1111; pwm = 4'b1111; run = 1'b1;
    repeat (16) @(negedge clk);
    vectors++;
    if (levels !== 4'b0001 || act !== 2'd1) begin
      miscompares++;
      $display("FAIL areset_pre: lv=%b act=%0d want 0001 1", levels, act);
    end
    #2 rst_n = 1'b0;
    #1;
    vectors++;
    if (busy !== 0 || clr !== 1 || en !== 0 || levels !== 0 || upd !== 0 ||
        act !== 0 || upd_ch !== 0) begin
      miscompares++;
      $display("FAIL areset_now: busy=%b clr=%b en=%b lv=%b upd=%b act=%0d uch=%0d",
               busy, clr, en, levels, upd, act, upd_ch);
    end
    run = 1'b0;
    m_last = NC - 1; exp_levels = '0;
    repeat (2) @(negedge clk);
    rst_n = 1'b1;
    test_schedule("areset_after", 4'b1111, 2, 1'b0, 4'b1111);
  endtask

  task automatic test_random();
    logic [NC-1:0] m;
    apply_reset();
    for (int r = 0; r < 4; r++) begin
      m = NC'($urandom_range(1, 15));
      test_schedule("random", m, 3 + int'($urandom_range(0, 3)), 1'b1, NC'($urandom));
    end
  endtask

  initial begin
    test_reset();
    test_all_channels();
    test_alternate();
    test_single();
    test_abort();
    test_run_drop();
    test_async_reset();
    test_random();
    $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
    $finish;
  end

endmodule

// File: doc/pwm_analyzer_scheduler.md
Name: pwm_analyzer_scheduler

Overview:
Time-shares one pwm_analyzer instance between NUM_CHANNELS PWM inputs. Visits each enabled channel round-robin and clears the analyzer. Routes the selected, synchronized PWM line to the analyzer enable for a fixed dwell window, then captures the analyzer's output level into a per-channel result register. Sits between the board PWM pins and the single analyzer; downstream logic reads levels_o.

Parameters:
NUM_CHANNELS, 4, number of PWM inputs sharing the analyzer (2..16)
CH_BITS, 2, width of channel index; must equal clog2(NUM_CHANNELS)
DWELL_CYCLES, 2000, clock cycles the analyzer is enabled per channel visit (>=2); matches analyzer MAX_COUNTER_VALUE

Ports:
clock_i  input  1  system clock, rising edge
reset_i  input  1  asynchronous, active-low reset
run_i  input  1  1 = keep scheduling; 0 = stop after current visit
channel_mask_i  input  NUM_CHANNELS  1 = channel participates
pwm_i  input  NUM_CHANNELS  asynchronous PWM inputs
analyzer_level_i  input  1  output_pin_o of the shared analyzer
analyzer_enable_o  output  1  drives analyzer enable_i
analyzer_clear_o  output  1  drives analyzer reset_i (active-high clear)
active_channel_o  output  CH_BITS  channel currently owning the analyzer
busy_o  output  1  1 in every state except IDLE
levels_o  output  NUM_CHANNELS  last captured level per channel
update_o  output  1  one-cycle pulse when a level is captured
update_channel_o  output  CH_BITS  channel written on update_o

Behaviour:
- Reset (reset_i low, async): state IDLE; analyzer_enable_o 0; analyzer_clear_o 1; levels_o 0; update_o 0; active_channel_o 0; update_channel_o 0; last-served pointer = NUM_CHANNELS-1, so the first visit is channel 0.
- pwm_i: 2-flop synchronizer per bit, always running; 2-cycle latency from pin to analyzer_enable_o.
- IDLE: clear 1, enable 0, busy 0. If run_i=1 and mask!=0 -> SELECT.
- SELECT (1 cycle): search from last+1 upward with wrap for the first set mask bit; register it as active_channel_o and last pointer -> CLEAR. If the mask became 0, go to IDLE.
- CLEAR (1 cycle): clear 1, enable 0; dwell counter := 0 -> DWELL.
- DWELL: clear 0; analyzer_enable_o = synchronized pwm_i[active]; counter +1 per cycle. At counter == DWELL_CYCLES-1 -> CAPTURE.
- CAPTURE (1 cycle): enable 0; levels_o[active] <= analyzer_level_i; update_o=1, update_channel_o=active. Next: SELECT if run_i=1 and mask!=0, else IDLE.
- Visit length: DWELL_CYCLES+3 cycles (SELECT+CLEAR+DWELL+CAPTURE). Single enabled channel: revisited back-to-back.
- Mask bit of active channel cleared during DWELL: abort. Go to SELECT next cycle with no capture, no update_o, levels_o unchanged.
- run_i deasserted during a visit: the visit completes, including capture, then IDLE.
- Mask changes take effect at the next SELECT, except the abort case above.
- Counter width: clog2(DWELL_CYCLES); no overflow possible.

Decomposition:
- Shared package/include: FSM state encodings (IDLE, SELECT, CLEAR, DWELL, CAPTURE) and the clog2 helper.
- Sub-module: pwm_sync, a parameterized 2-flop synchronizer with async active-low reset to 0. The round-robin search stays inline as a combinational loop.

Test Plan:
Bench uses DWELL_CYCLES=8 and NUM_CHANNELS=4, driving a behavioural analyzer model that outputs 1 when the enabled-cycle count exceeds 4.
- Reset then run_i=1, mask=4'b1111, all pwm_i=1 -> update_o pulses for channels 0,1,2,3 in order, 11 cycles apart; levels_o=4'b1111.
- mask=4'b1010, pwm_i[1]=1, pwm_i[3]=0 -> visits alternate 1,3,1,...; levels_o=4'b0010; channels 0 and 2 never active.
- mask=4'b0100 only -> channel 2 revisited every 11 cycles; analyzer_clear_o high exactly 1 cycle before each dwell.
- Clear mask[active] at cycle 3 of a dwell -> no update_o for that channel, its level unchanged, next enabled channel selected the following cycle.
- run_i dropped mid-dwell -> current channel still captured (update_o=1), then busy_o=0 and clear=1 held.
- Assert reset_i low mid-dwell -> all outputs at reset values immediately (async); after release and run_i=1, first visit is channel 0.
